// File: rtl/dm_byte_ctrl_if.sv
// Access bundle for dm_byte_ctrl: the master issues byte/halfword/word
// loads and stores; the slave answers with ready, rvalid/dout and err.

interface dm_byte_ctrl_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] din;
   logic        ready;
   logic        rvalid;
   logic [31:0] dout;
   logic        err;

   modport master (
      output req, we, size, sign_ext, addr, din,
      input  ready, rvalid, dout, err
   );

   modport slave (
      input  req, we, size, sign_ext, addr, din,
      output ready, rvalid, dout, err
   );
endinterface

// File: rtl/dm_byte_ctrl.sv
// Byte-addressable data memory with lane-masked stores and fixed-latency,
// extended loads. Macro DM_BOUND_CHK_EN rejects addresses beyond the array.

module dm_byte_ctrl #(
   parameter int DEPTH_LOG2 = 7,
   parameter int RD_LAT     = 1
) (
   input  logic          CLK,
   input  logic          RSTN,
   dm_byte_ctrl_if.slave bus
);

   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("dm_byte_ctrl: RD_LAT must be within 1..4");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_t;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  err_q;

   logic [31:0]           mem [DEPTH];
   logic [31:0]           word_q;
   logic [1:0]            lane_q;
   size_t                 size_q;
   logic                  sext_q;

   logic [DEPTH_LOG2-1:0] idx;
   logic [1:0]            lane;
   size_t                 size;
   logic                  accept;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  reject;
   logic                  do_store;
   logic                  do_load;
   logic [3:0]            lane_en;
   logic [31:0]           wdata;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [31:0]           load_val;
   logic                  rvalid;

   assign idx    = bus.addr[DEPTH_LOG2+1:2];
   assign lane   = bus.addr[1:0];
   assign size   = size_t'(bus.size);
   assign accept = bus.req & bus.ready;

   always_comb begin
      unique case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = lane[0];
         SZ_WORD: misaligned = |lane;
         default: misaligned = 1'b1;
      endcase
   end

`ifdef DM_BOUND_CHK_EN
   assign out_of_range = |bus.addr[31:DEPTH_LOG2+2];
`else
   // Upper address bits wrap the word index instead of being checked.
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.addr[31:DEPTH_LOG2+2];
   assign out_of_range   = 1'b0;
`endif

   assign reject   = misaligned | out_of_range;
   assign do_store = accept &  bus.we & ~reject;
   assign do_load  = accept & ~bus.we & ~reject;

   // Store data is replicated across lanes so each lane enable picks its byte.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      lane_en = 4'b0000;
      wdata   = bus.din;
      unique case (size)
         SZ_BYTE: begin
            lane_en = 4'b0001 << lane;
            wdata   = {4{bus.din[7:0]}};
         end
         SZ_HALF: begin
            lane_en = lane[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{bus.din[15:0]}};
         end
         SZ_WORD: lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   end

   // NOTE: the storage array is deliberately left out of reset; contents must survive RSTN.
   always_ff @(posedge CLK) begin
      if (do_store) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // The word is snapshotted at acceptance; extraction happens on the way out.
   always_ff @(posedge CLK) begin
      if (do_load) begin
         word_q <= mem[idx];
         lane_q <= lane;
         size_q <= size;
         sext_q <= bus.sign_ext;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (do_load) begin
               if (RD_LAT == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = RD_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= accept & reject;
      end
   end

   always_comb begin
      byte_sel = word_q[{lane_q, 3'b000} +: 8];
      half_sel = word_q[{lane_q[1], 4'b0000} +: 16];
      load_val = word_q;
      unique case (size_q)
         SZ_BYTE: load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_val = {{16{sext_q & half_sel[15]}}, half_sel};
         default: load_val = word_q;
      endcase
   end

   assign rvalid     = (state_q == RESP);
   assign bus.ready  = (state_q != RD_WAIT);
   assign bus.rvalid = rvalid;
   assign bus.dout   = rvalid ? load_val : 32'd0;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_dm_byte_ctrl.sv
// Bench for dm_byte_ctrl: three instances (RD_LAT 1, 2, 3) checked every cycle
// against a transaction-level memory model, plus literal directed checks.

module tb_dm_byte_ctrl;

   localparam int NI    = 3;
   localparam int DL    = 7;
   localparam int WORDS = 1 << DL;
`ifdef DM_BOUND_CHK_EN
   localparam bit BOUND = 1'b1;
`else
   localparam bit BOUND = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_v  [NI];
   logic        we_v   [NI];
   logic [1:0]  size_v [NI];
   logic        sx_v   [NI];
   logic [31:0] addr_v [NI];
   logic [31:0] din_v  [NI];
   logic        rdy    [NI];
   logic        rv     [NI];
   logic [31:0] dout_v [NI];
   logic        err_v  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dm_byte_ctrl_if bus ();
      assign bus.req      = req_v[g];
      assign bus.we       = we_v[g];
      assign bus.size     = size_v[g];
      assign bus.sign_ext = sx_v[g];
      assign bus.addr     = addr_v[g];
      assign bus.din      = din_v[g];
      assign rdy[g]       = bus.ready;
      assign rv[g]        = bus.rvalid;
      assign dout_v[g]    = bus.dout;
      assign err_v[g]     = bus.err;

      dm_byte_ctrl #(
         .DEPTH_LOG2 (DL),
         .RD_LAT     (g + 1)
      ) u_dut (
         .CLK  (clk),
         .RSTN (rst_n),
         .bus  (bus)
      );
   end

   int total = 0;
   int bad   = 0;
   bit cmp_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] mem_m  [NI][WORDS];
   logic        e_rdy  [NI];
   logic        e_rv   [NI];
   logic        e_err  [NI];
   logic [31:0] e_dout [NI];
   logic        pend   [NI];
   int          resp_e [NI];
   logic [31:0] val_m  [NI];
   int          cyc = 0;

   function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
             (BOUND && (a >> (DL + 2)) != 0);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % WORDS);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] a, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      for (int b = 0; b < 4; b++) begin
         if (sz == 2'd2)                       r[8*b +: 8] = d[8*b +: 8];
         else if (sz == 2'd1 && (b / 2) == a[1]) r[8*b +: 8] = d[8*(b % 2) +: 8];
         else if (sz == 2'd0 && b == int'(a))  r[8*b +: 8] = d[7:0];
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sx, input logic [1:0] a);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * a)) & 32'h0000_00FF;
         if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * a[1])) & 32'h0000_FFFF;
         if (sx && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic        p, rvx, er;
      int          r, c;
      logic [31:0] v, dv;
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            pend[i]   <= 1'b0;
            e_rdy[i]  <= 1'b1;
            e_rv[i]   <= 1'b0;
            e_err[i]  <= 1'b0;
            e_dout[i] <= 32'd0;
         end
      end else begin
         c = cyc + 1;
         cyc <= c;
         for (int i = 0; i < NI; i++) begin
            p   = pend[i];
            r   = resp_e[i];
            v   = val_m[i];
            rvx = 1'b0;
            er  = 1'b0;
            dv  = 32'd0;
            if (req_v[i] && e_rdy[i]) begin
               if (is_bad(size_v[i], addr_v[i])) begin
                  er = 1'b1;
               end else if (we_v[i]) begin
                  mem_m[i][widx(addr_v[i])] <= merge(mem_m[i][widx(addr_v[i])], size_v[i],
                                                     addr_v[i][1:0], din_v[i]);
               end else begin
                  p = 1'b1;
                  r = c + (i + 1) - 1;
                  v = ref_load(mem_m[i][widx(addr_v[i])], size_v[i], sx_v[i], addr_v[i][1:0]);
               end
            end
            if (p && r == c) begin
               rvx = 1'b1;
               dv  = v;
               p   = 1'b0;
            end
            pend[i]   <= p;
            resp_e[i] <= r;
            val_m[i]  <= v;
            e_rdy[i]  <= !(p && r > c);
            e_rv[i]   <= rvx;
            e_err[i]  <= er;
            e_dout[i] <= dv;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on && rst_n) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("ready[%0d] cyc %0d", i, cyc), rdy[i], e_rdy[i]);
            check($sformatf("rvalid[%0d] cyc %0d", i, cyc), rv[i], e_rv[i]);
            check($sformatf("dout[%0d] cyc %0d", i, cyc), dout_v[i], e_dout[i]);
            check($sformatf("err[%0d] cyc %0d", i, cyc), err_v[i], e_err[i]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int i, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      while (!rdy[i] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[i]) check("ready_timeout", 32'd0, 32'd1);
      req_v[i]  = 1'b1;
      we_v[i]   = w;
      size_v[i] = sz;
      sx_v[i]   = sx;
      addr_v[i] = a;
      din_v[i]  = d;
      @(negedge clk);
      req_v[i] = 1'b0;
   endtask

   task automatic load(input int i, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       output logic [31:0] data, output int lat);
      drive(i, 1'b0, sz, sx, a, 32'd0);
      lat = 1;
      while (!rv[i] && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (!rv[i]) check("rvalid_timeout", 32'd0, 32'd1);
      data = dout_v[i];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, a;
      logic [1:0]  sz;
      int          l, n_low, saw;
      for (int i = 0; i < NI; i++) begin
         req_v[i] = 1'b0; we_v[i] = 1'b0; size_v[i] = 2'd0; sx_v[i] = 1'b0;
         addr_v[i] = 32'd0; din_v[i] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      cmp_on = 1'b1;
      @(negedge clk);
      check("reset_ready", rdy[0], 1'b1);
      check("reset_rvalid", rv[0], 1'b0);
      check("reset_dout", dout_v[0], 32'd0);

      for (int i = 0; i < NI; i++) begin
         for (int w = 0; w < WORDS; w++) drive(i, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
      end

      // RD_LAT = 1 instance
      drive(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      load(0, 2'd2, 1'b0, 32'h10, d, l);
      check("lat1_word", d, 32'hDEADBEEF);
      check("lat1_cycles", l, 1);
      check("lat1_ready_in_resp", rdy[0], 1'b1);
      drive(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
      drive(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF5A);
      load(0, 2'd2, 1'b0, 32'h10, d, l);
      check("byte_merge", d, 32'h5A223344);
      load(0, 2'd0, 1'b1, 32'h13, d, l);
      check("byte_sx_pos", d, 32'h0000005A);
      drive(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680);
      load(0, 2'd0, 1'b1, 32'h13, d, l);
      check("byte_sx_neg", d, 32'hFFFFFF80);
      load(0, 2'd0, 1'b0, 32'h13, d, l);
      check("byte_zx", d, 32'h00000080);

      drive(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
      drive(0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000BEEF);
      check("mis_half_err", err_v[0], 1'b1);
      @(negedge clk);
      check("mis_half_err_pulse", err_v[0], 1'b0);
      load(0, 2'd2, 1'b0, 32'h20, d, l);
      check("mis_half_nowrite", d, 32'hCAFEF00D);
      drive(0, 1'b0, 2'd2, 1'b0, 32'h22, 32'd0);
      check("mis_word_err", err_v[0], 1'b1);
      check("mis_word_norv", rv[0], 1'b0);
      drive(0, 1'b0, 2'd3, 1'b0, 32'h20, 32'd0);
      check("size11_err", err_v[0], 1'b1);
      load(0, 2'd1, 1'b1, 32'h22, d, l);
      check("half_hi_sx", d, 32'hFFFFCAFE);
      load(0, 2'd1, 1'b0, 32'h20, d, l);
      check("half_lo_zx", d, 32'h0000F00D);

      drive(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678);
      drive(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h1);
      check("bound_err", err_v[0], BOUND);
      load(0, 2'd2, 1'b0, 32'h0, d, l);
      check("bound_word0", d, BOUND ? 32'h12345678 : 32'h1);

      // RD_LAT = 3 instance: request held through the wait
      drive(2, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0BADF00D);
      req_v[2] = 1'b1; we_v[2] = 1'b0; size_v[2] = 2'd2; sx_v[2] = 1'b0; addr_v[2] = 32'h0;
      l = 0;
      n_low = 0;
      do begin
         @(negedge clk);
         l++;
         if (!rdy[2]) n_low++;
      end while (!rv[2] && l < 10);
      req_v[2] = 1'b0;
      check("lat3_cycles", l, 3);
      check("lat3_ready_low", n_low, 2);
      check("lat3_data", dout_v[2], 32'h0BADF00D);
      load(2, 2'd2, 1'b0, 32'h0, d, l);
      check("lat3_b2b_cycles", l, 3);

      // RD_LAT = 2 instance: reset in the middle of a read
      drive(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A50001);
      drive(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
      check("lat2_wait_ready", rdy[1], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_ready", rdy[1], 1'b1);
      check("rst_async_rvalid", rv[1], 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      saw = 0;
      repeat (3) begin
         @(negedge clk);
         if (rv[1]) saw++;
      end
      check("rst_no_rvalid", saw, 0);
      load(1, 2'd2, 1'b0, 32'h40, d, l);
      check("rst_mem_kept", d, 32'hA5A50001);
      check("lat2_cycles", l, 2);

      // Randomized traffic, checked by the model every cycle
      for (int i = 0; i < NI; i++) begin
         repeat (250) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 4 * WORDS - 1));
            if ($urandom_range(0, 3) != 0) begin
               if (sz == 2'd1) a[0] = 1'b0;
               if (sz == 2'd2) a[1:0] = 2'd0;
            end
            if ($urandom_range(0, 9) == 0) a = a | ($urandom() << (DL + 2));
            drive(i, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      repeat (6) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dm_byte_ctrl.md
DM_BYTE_CTRL -- requirements
Module: dm_byte_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 7: memory holds 2**DEPTH_LOG2 32-bit words (128 default).
REQ-002 Parameter RD_LAT, default 1: read latency in cycles, legal range 1..4; other values are an elaboration error.
REQ-003 Port CLK  in  1: single clock; all state changes on the rising edge.
REQ-004 Port RSTN  in  1: reset, asynchronous, active-low.
REQ-005 Port req  in  1: access request; accepted on a rising edge where req=1 and ready=1.
REQ-006 Port we  in  1: 1 = store, 0 = load; sampled at acceptance.
REQ-007 Port size  in  2: 00 byte, 01 halfword, 10 word; 11 is illegal (treated as misaligned).
REQ-008 Port sign_ext  in  1: load result sign-extended when 1, zero-extended when 0; ignored for word loads.
REQ-009 Port addr  in  32: byte address; word index = addr[DEPTH_LOG2+1:2], lane = addr[1:0].
REQ-010 Port din  in  32: store data, right-aligned (byte in din[7:0], halfword in din[15:0]).
REQ-011 Port ready  out  1: block can accept a request this cycle.
REQ-012 Port rvalid  out  1: one-cycle pulse; dout holds load result.
REQ-013 Port dout  out  32: extracted, extended load data; valid only while rvalid=1.
REQ-014 Port err  out  1: one-cycle pulse flagging a rejected access.

Function
REQ-015 States: IDLE (ready=1), RD_WAIT (ready=0, counting), RESP (rvalid=1, ready=1).
REQ-016 Store accepted in IDLE/RESP: memory updated at the accepting edge, only byte lanes selected by size/addr[1:0]; other lanes unchanged; no rvalid; ready stays 1.
REQ-017 Byte store writes din[7:0] to lane addr[1:0]; halfword store writes din[15:0] to lanes {addr[1],0} and {addr[1],1}; word store writes all four lanes.
REQ-018 Load accepted at edge k: rvalid=1 in the cycle following edge k+RD_LAT-1; ready=0 from edge k until that cycle (RD_LAT-1 cycles; none when RD_LAT=1).
REQ-019 ready=1 during RESP; a request accepted in RESP is processed normally (back-to-back loads sustain one per RD_LAT cycles).
REQ-020 Load data is the memory word as of the accepting edge; a store accepted at edge k-1 is visible to a load accepted at edge k.
REQ-021 Lane extraction: byte = word[8*addr[1:0]+7 : 8*addr[1:0]], halfword = word[16*addr[1]+15 : 16*addr[1]]; extension per sign_ext.
REQ-022 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0, or size=11; no memory change, no rvalid, err=1 in the cycle after acceptance, ready stays 1.
REQ-023 Address bits above DEPTH_LOG2+1 are ignored (index wraps) unless REQ-028 applies.
REQ-024 dout=0 whenever rvalid=0.
REQ-025 req while ready=0 is ignored, not queued.

Reset
REQ-026 RSTN low: state=IDLE, ready=1, rvalid=0, err=0, dout=0, latency counter cleared, immediately and asynchronously.
REQ-027 A load outstanding at reset is discarded; memory contents are not reset and remain intact.

Configuration
REQ-028 Macro DM_BOUND_CHK_EN defined: an access with any of addr[31:DEPTH_LOG2+2] nonzero is rejected exactly as in REQ-022 (err pulse, no write, no rvalid); undefined: such addresses wrap per REQ-023 and never raise err.

Verification
REQ-029 RD_LAT=1: word store 0xDEADBEEF @0x10, then load word @0x10 -> rvalid next cycle, dout=0xDEADBEEF, ready never low.
REQ-030 Byte store 0x5A @0x13 over 0x11223344, load word @0x10 -> 0x5A223344; load byte @0x13 sign_ext=1 -> 0x0000005A; store 0x80 there, signed byte load -> 0xFFFFFF80, unsigned -> 0x00000080.
REQ-031 RD_LAT=3: load @0x0 -> ready low 2 cycles, rvalid in 3rd cycle after acceptance; req held during wait is not accepted early.
REQ-032 Halfword store @0x21 -> err pulse next cycle, word @0x20 unchanged; word load @0x22 -> err, no rvalid.
REQ-033 RD_LAT=2, assert RSTN low mid-read -> rvalid never asserted, ready=1 immediately; prior stored data still readable afterwards.
REQ-034 Store 0x1 @0x200 (DEPTH_LOG2=7): with DM_BOUND_CHK_EN -> err, @0x0 unchanged; without -> @0x0 reads 0x1.
